inst_fetch: RTL and testbench

- Program-counter and instruction-fetch stage that sits directly upstream of the control decoder.
- Holds the PC and drives the synchronous instruction ROM.
- Presents each fetched machine word on op_cde with a valid flag, and redirects on pgm_jmp.
- Stops on ack (DNE) and raises done until the next start.

---
 rtl/inst_fetch_pkg.sv | 30 +++
 rtl/inst_fetch_pc_reg.sv | 57 +++++
 rtl/inst_fetch.sv | 179 +++++++++++++++++
 tb/tb_inst_fetch.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, bubble encoding,
// fetch FSM state codes and next-address select codes.
package inst_fetch_pkg;

  localparam int OPCDE_W = 9;
  localparam int PC_W    = 8;
  localparam int CNT_W   = 16;

  // Bubble must decode as no write, no jump, no ack in the control decoder.
  localparam logic [OPCDE_W-1:0] BUBBLE = 9'h000;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] SEL_HOLD  = 2'd0;
  localparam logic [1:0] SEL_START = 2'd1;
  localparam logic [1:0] SEL_JUMP  = 2'd2;
  localparam logic [1:0] SEL_INC   = 2'd3;

  // Increment with carry-out; the MSB flags a wrap from all-ones to zero.
  function automatic logic [PC_W:0] pc_inc(input logic [PC_W-1:0] addr);
    return {1'b0, addr} + {{PC_W{1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/inst_fetch_pc_reg.sv
// Fetch-address and PC registers with the next-address mux
// (hold / start / jump / increment) and wrap detection.
module inst_fetch_pc_reg
  import inst_fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      sel,
  input  logic            pc_load,
  input  logic [PC_W-1:0] start_addr,
  input  logic [PC_W-1:0] jmp_tgt,
  output logic [PC_W-1:0] fetch_addr,
  output logic [PC_W-1:0] pc,
  output logic            wrap
);

  logic [PC_W-1:0] fetch_addr_r;
  logic [PC_W-1:0] pc_r;
  logic [PC_W-1:0] fetch_nxt_s;
  logic [PC_W:0]   inc_s;

  // Next fetch address selection; wrap only reported on an increment.
  always_comb begin
    inc_s       = pc_inc(fetch_addr_r);
    fetch_nxt_s = fetch_addr_r;
    wrap        = 1'b0;
    case (sel)
      SEL_HOLD:  fetch_nxt_s = fetch_addr_r;
      SEL_START: fetch_nxt_s = start_addr;
      SEL_JUMP:  fetch_nxt_s = jmp_tgt;
      SEL_INC: begin
        fetch_nxt_s = inc_s[PC_W-1:0];
        wrap        = inc_s[PC_W];
      end
      default:   fetch_nxt_s = fetch_addr_r;
    endcase
  end

  // The word read at fetch_addr is presented next cycle, so pc trails it by one load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_addr_r <= {PC_W{1'b0}};
      pc_r         <= {PC_W{1'b0}};
    end else begin
      fetch_addr_r <= fetch_nxt_s;
      if (pc_load) begin
        pc_r <= fetch_addr_r;
      end else begin
        pc_r <= pc_r;
      end
    end
  end

  assign fetch_addr = fetch_addr_r;
  assign pc         = pc_r;

endmodule

// File: rtl/inst_fetch.sv
// Program-counter / instruction-fetch stage feeding the control decoder:
// start, sequential fetch, 1-bubble jumps, stall hold, DNE stop and retire count.
module inst_fetch
  import inst_fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [PC_W-1:0]    start_addr,
  input  logic               stall,
  input  logic               pgm_jmp,
  input  logic [PC_W-1:0]    jmp_tgt,
  input  logic               ack,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [OPCDE_W-1:0] imem_data,
  output logic [OPCDE_W-1:0] op_cde,
  output logic               op_vld,
  output logic [PC_W-1:0]    pc,
  output logic               done,
  output logic               pc_ovf,
  output logic [CNT_W-1:0]   ins_cnt
);

  logic [1:0]         state_r, state_nxt_s;
  logic               op_vld_r, op_vld_nxt_s;
  logic               squash_r, squash_nxt_s;
  logic               done_r, done_nxt_s;
  logic               pc_ovf_r;
  logic [CNT_W-1:0]   ins_cnt_r;
  logic               held_r;
  logic [OPCDE_W-1:0] held_data_r;
  logic [1:0]         sel_s;
  logic               pc_load_s;
  logic               ovf_en_s;
  logic               wrap_s;
  logic               start_go_s;
  logic               live_s;
  logic               ack_go_s;
  logic               jmp_go_s;

  assign start_go_s = start && !stall && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign live_s     = op_vld_r && !stall;
  assign ack_go_s   = live_s && ack;
  assign jmp_go_s   = live_s && pgm_jmp && !ack;

  inst_fetch_pc_reg u_pc_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .sel        (sel_s),
    .pc_load    (pc_load_s),
    .start_addr (start_addr),
    .jmp_tgt    (jmp_tgt),
    .fetch_addr (imem_addr),
    .pc         (pc),
    .wrap       (wrap_s)
  );

  // Fetch FSM: next state, address select and valid/squash/done updates.
  always_comb begin
    state_nxt_s  = state_r;
    op_vld_nxt_s = op_vld_r;
    squash_nxt_s = squash_r;
    done_nxt_s   = done_r;
    sel_s        = SEL_HOLD;
    pc_load_s    = 1'b0;
    ovf_en_s     = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start_go_s) begin
          state_nxt_s = ST_PRIME;
          sel_s       = SEL_START;
          done_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_PRIME: begin
        if (!stall) begin
          state_nxt_s  = ST_RUN;
          sel_s        = SEL_INC;
          pc_load_s    = 1'b1;
          ovf_en_s     = 1'b1;
          op_vld_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_PRIME;
        end
      end
      ST_RUN: begin
        if (stall) begin
          state_nxt_s = ST_RUN;
        end else if (ack_go_s) begin
          state_nxt_s  = ST_DONE;
          done_nxt_s   = 1'b1;
          op_vld_nxt_s = 1'b0;
          squash_nxt_s = 1'b0;
        end else if (jmp_go_s) begin
          sel_s        = SEL_JUMP;
          pc_load_s    = 1'b1;
          op_vld_nxt_s = 1'b0;
          squash_nxt_s = 1'b1;
        end else if (squash_r) begin
          // fetch_addr already holds the target; stepping it is a jump follow-on, not a wrap.
          sel_s        = SEL_INC;
          pc_load_s    = 1'b1;
          op_vld_nxt_s = 1'b1;
          squash_nxt_s = 1'b0;
        end else begin
          sel_s     = SEL_INC;
          pc_load_s = 1'b1;
          ovf_en_s  = 1'b1;
        end
      end
      default: begin
        state_nxt_s  = ST_IDLE;
        op_vld_nxt_s = 1'b0;
        squash_nxt_s = 1'b0;
        done_nxt_s   = 1'b0;
      end
    endcase
  end

  // FSM and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      op_vld_r <= 1'b0;
      squash_r <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      op_vld_r <= op_vld_nxt_s;
      squash_r <= squash_nxt_s;
      done_r   <= done_nxt_s;
    end
  end

  // Sticky wrap flag and saturating retired-instruction counter, cleared by start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_ovf_r  <= 1'b0;
      ins_cnt_r <= {CNT_W{1'b0}};
    end else if (start_go_s) begin
      pc_ovf_r  <= 1'b0;
      ins_cnt_r <= {CNT_W{1'b0}};
    end else begin
      pc_ovf_r <= pc_ovf_r | (wrap_s & ovf_en_s);
      if (live_s && (ins_cnt_r != CNT_MAX)) begin
        ins_cnt_r <= ins_cnt_r + CNT_ONE;
      end else begin
        ins_cnt_r <= ins_cnt_r;
      end
    end
  end

  // The ROM moves on to the next address while stalled, so capture the presented word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_r      <= 1'b0;
      held_data_r <= BUBBLE;
    end else if (stall && op_vld_r) begin
      if (!held_r) begin
        held_r      <= 1'b1;
        held_data_r <= imem_data;
      end else begin
        held_data_r <= held_data_r;
      end
    end else begin
      held_r      <= 1'b0;
      held_data_r <= held_data_r;
    end
  end

  assign op_cde  = op_vld_r ? (held_r ? held_data_r : imem_data) : BUBBLE;
  assign op_vld  = op_vld_r;
  assign done    = done_r;
  assign pc_ovf  = pc_ovf_r;
  assign ins_cnt = ins_cnt_r;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: directed program flow with a synchronous ROM model.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [PC_W-1:0]    start_addr = 8'h00;
  logic               stall = 1'b0;
  logic               pgm_jmp = 1'b0;
  logic [PC_W-1:0]    jmp_tgt = 8'h00;
  logic               ack = 1'b0;
  logic [PC_W-1:0]    imem_addr;
  logic [OPCDE_W-1:0] imem_data = 9'h000;
  logic [OPCDE_W-1:0] op_cde;
  logic               op_vld;
  logic [PC_W-1:0]    pc;
  logic               done;
  logic               pc_ovf;
  logic [CNT_W-1:0]   ins_cnt;

  int checks = 0;
  int failures = 0;
  logic [PC_W-1:0] exp_q[$];

  inst_fetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .stall      (stall),
    .pgm_jmp    (pgm_jmp),
    .jmp_tgt    (jmp_tgt),
    .ack        (ack),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .op_cde     (op_cde),
    .op_vld     (op_vld),
    .pc         (pc),
    .done       (done),
    .pc_ovf     (pc_ovf),
    .ins_cnt    (ins_cnt)
  );

  always #5 clk = ~clk;

  // ROM contents: MSB set so no word collides with the bubble encoding.
  function automatic logic [OPCDE_W-1:0] rom_word(input logic [PC_W-1:0] a);
    return {1'b1, a ^ 8'hA5};
  endfunction

  always @(posedge clk) imem_data <= rom_word(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: each accepted instruction must be the next one in the expected stream.
  always @(negedge clk) begin
    if (rst_n && op_vld && !stall) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_extra: got pc %0h expected no instruction", pc);
      end else begin
        logic [PC_W-1:0] e;
        e = exp_q.pop_front();
        check("sb_pc", {24'h0, pc}, {24'h0, e});
        check("sb_op", {23'h0, op_cde}, {23'h0, rom_word(e)});
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_vld"}, {31'h0, op_vld}, 32'h0);
    check({tag, "_op"}, {23'h0, op_cde}, 32'h0);
    check({tag, "_pc"}, {24'h0, pc}, 32'h0);
    check({tag, "_addr"}, {24'h0, imem_addr}, 32'h0);
    check({tag, "_done"}, {31'h0, done}, 32'h0);
    check({tag, "_ovf"}, {31'h0, pc_ovf}, 32'h0);
    check({tag, "_cnt"}, {16'h0, ins_cnt}, 32'h0);
  endtask

  initial begin
    tick(2);
    check_reset_vals("rst");
    rst_n = 1'b1;
    tick(1);

    // Linear run from 0x10, then jump to 0x40 at pc 0x12.
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h40, 8'h41, 8'h20, 8'h21, 8'h22,
              8'h60, 8'h61, 8'h03, 8'h04, 8'h05};
    start = 1'b1; start_addr = 8'h10;
    tick(1); start = 1'b0;
    check("prime_vld", {31'h0, op_vld}, 32'h0);
    tick(1);
    check("first_vld", {31'h0, op_vld}, 32'h1);
    check("first_pc", {24'h0, pc}, 32'h10);
    tick(1);
    check("cnt_1", {16'h0, ins_cnt}, 32'd1);
    tick(1);
    check("pc_12", {24'h0, pc}, 32'h12);
    check("cnt_2", {16'h0, ins_cnt}, 32'd2);
    pgm_jmp = 1'b1; jmp_tgt = 8'h40;
    tick(1); pgm_jmp = 1'b0;
    check("squash_vld", {31'h0, op_vld}, 32'h0);
    check("squash_op", {23'h0, op_cde}, 32'h0);
    tick(1);
    check("tgt_pc", {24'h0, pc}, 32'h40);
    tick(1);
    check("cnt_no_squash", {16'h0, ins_cnt}, 32'd4);

    // Jump to 0x20, then stall 3 cycles at 0x22 with a jump pending.
    pgm_jmp = 1'b1; jmp_tgt = 8'h20;
    tick(1); pgm_jmp = 1'b0;
    tick(3);
    check("pc_22", {24'h0, pc}, 32'h22);
    stall = 1'b1; pgm_jmp = 1'b1; jmp_tgt = 8'h60;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("stall_pc", {24'h0, pc}, 32'h22);
      check("stall_op", {23'h0, op_cde}, {23'h0, rom_word(8'h22)});
      check("stall_vld", {31'h0, op_vld}, 32'h1);
      check("stall_cnt", {16'h0, ins_cnt}, 32'd7);
    end
    stall = 1'b0;
    tick(1); pgm_jmp = 1'b0;
    check("rel_bubble", {31'h0, op_vld}, 32'h0);
    check("rel_cnt", {16'h0, ins_cnt}, 32'd8);
    tick(1);
    check("rel_tgt", {24'h0, pc}, 32'h60);
    tick(1);

    // Jump to 0x03; ack together with pgm_jmp at 0x05.
    pgm_jmp = 1'b1; jmp_tgt = 8'h03;
    tick(1); pgm_jmp = 1'b0;
    tick(3);
    check("pc_05", {24'h0, pc}, 32'h05);
    ack = 1'b1; pgm_jmp = 1'b1; jmp_tgt = 8'h70;
    tick(1); ack = 1'b0; pgm_jmp = 1'b0;
    check("dne_done", {31'h0, done}, 32'h1);
    check("dne_vld", {31'h0, op_vld}, 32'h0);
    check("dne_op", {23'h0, op_cde}, 32'h0);
    check("dne_cnt", {16'h0, ins_cnt}, 32'd13);
    check("dne_no_redirect", {24'h0, imem_addr}, 32'h06);
    tick(1);
    check("done_held", {31'h0, done}, 32'h1);
    check("done_vld", {31'h0, op_vld}, 32'h0);
    check("done_cnt", {16'h0, ins_cnt}, 32'd13);

    // Restart at 0x00, then async reset between edges.
    exp_q.push_back(8'h00);
    start = 1'b1; start_addr = 8'h00;
    tick(1); start = 1'b0;
    check("restart_done", {31'h0, done}, 32'h0);
    check("restart_cnt", {16'h0, ins_cnt}, 32'h0);
    tick(1);
    check("restart_pc", {24'h0, pc}, 32'h00);
    check("restart_vld", {31'h0, op_vld}, 32'h1);
    tick(1);
    check("restart_pc1", {24'h0, pc}, 32'h01);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async");
    tick(2);
    rst_n = 1'b1;
    ack = 1'b1; pgm_jmp = 1'b1; jmp_tgt = 8'h33;
    tick(3);
    ack = 1'b0; pgm_jmp = 1'b0;
    check("idle_vld", {31'h0, op_vld}, 32'h0);
    check("idle_addr", {24'h0, imem_addr}, 32'h0);
    check("idle_done", {31'h0, done}, 32'h0);
    check("idle_cnt", {16'h0, ins_cnt}, 32'h0);

    // Wrap from 0xFF to 0x00, then counter saturation.
    exp_q = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02};
    start = 1'b1; start_addr = 8'hFE;
    tick(1); start = 1'b0;
    tick(1);
    check("wrap_pc_fe", {24'h0, pc}, 32'hFE);
    check("wrap_ovf_pre", {31'h0, pc_ovf}, 32'h0);
    tick(2);
    check("wrap_pc_00", {24'h0, pc}, 32'h00);
    check("wrap_ovf", {31'h0, pc_ovf}, 32'h1);
    force dut.ins_cnt_r = 16'hFFFE;
    #1 release dut.ins_cnt_r;
    tick(1);
    check("sat_ffff", {16'h0, ins_cnt}, 32'hFFFF);
    tick(1);
    check("sat_hold", {16'h0, ins_cnt}, 32'hFFFF);
    ack = 1'b1;
    tick(1); ack = 1'b0;
    check("end_done", {31'h0, done}, 32'h1);
    check("end_ovf_sticky", {31'h0, pc_ovf}, 32'h1);
    check("end_cnt", {16'h0, ins_cnt}, 32'hFFFF);
    tick(1);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
